// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: after reset it sweeps FILL_WORD into every word,
// then services registered reads (one-cycle latency) and program-load writes.
module instr_mem_loadable #(
    parameter int                    DATA_WIDTH = 10,
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    DEPTH      = 1024,
    parameter logic [DATA_WIDTH-1:0] FILL_WORD  = 10'b0010000010
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  rd_valid,
    output logic                  ready,
    input  logic                  ld_en,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  ld_ack
);

    localparam int                    IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_A  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e                  state_q;
    state_e                  state_d;
    logic [IDX_W-1:0]        clr_cnt_q;
    logic [IDX_W-1:0]        clr_cnt_d;
    logic [DATA_WIDTH-1:0]   mem_q [0:DEPTH-1];
    logic [DATA_WIDTH-1:0]   read_data_q;
    logic                    rd_valid_q;
    logic                    ld_ack_q;
    logic                    ready_q;

    logic                    rd_in_range_s;
    logic                    ld_in_range_s;
    logic [IDX_W-1:0]        rd_idx_s;
    logic                    rd_accept_s;
    logic                    ld_accept_s;
    logic                    wr_en_s;
    logic [IDX_W-1:0]        wr_idx_s;
    logic [DATA_WIDTH-1:0]   wr_data_s;

    // Out-of-range addresses must never alias onto real words, so compare against DEPTH.
    assign rd_in_range_s = ({1'b0, address} < DEPTH_A);
    assign ld_in_range_s = ({1'b0, ld_addr} < DEPTH_A);
    assign rd_idx_s      = address[IDX_W-1:0];

    // State register and clear-sweep counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= {IDX_W{1'b0}};
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next-state logic: the sweep ends on the edge that writes the last word.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_cnt_q == LAST_IDX) begin
                    state_d   = ST_RUN;
                    clr_cnt_d = {IDX_W{1'b0}};
                end else begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = clr_cnt_q + IDX_W'(1);
                end
            end
            ST_RUN: begin
                state_d   = ST_RUN;
                clr_cnt_d = {IDX_W{1'b0}};
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = {IDX_W{1'b0}};
            end
        endcase
    end

    // Output decode: which requests are accepted and what the write port does this cycle.
    always_comb begin
        rd_accept_s = 1'b0;
        ld_accept_s = 1'b0;
        wr_en_s     = 1'b0;
        wr_idx_s    = {IDX_W{1'b0}};
        wr_data_s   = FILL_WORD;
        case (state_q)
            ST_CLEAR: begin
                wr_en_s   = ~reset;
                wr_idx_s  = clr_cnt_q;
                wr_data_s = FILL_WORD;
            end
            ST_RUN: begin
                rd_accept_s = rd_en & ~reset;
                ld_accept_s = ld_en & ld_in_range_s & ~reset;
                wr_en_s     = ld_accept_s;
                wr_idx_s    = ld_addr[IDX_W-1:0];
                wr_data_s   = ld_data;
            end
            default: begin
                rd_accept_s = 1'b0;
                ld_accept_s = 1'b0;
                wr_en_s     = 1'b0;
            end
        endcase
    end

    // Storage array; no reset because the clear sweep initialises it.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_idx_s] <= wr_data_s;
        end
    end

    // Registered outputs; the read samples the array before this edge's write (read-first).
    always_ff @(posedge clk) begin
        if (reset) begin
            read_data_q <= {DATA_WIDTH{1'b0}};
            rd_valid_q  <= 1'b0;
            ld_ack_q    <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            rd_valid_q <= rd_accept_s;
            ld_ack_q   <= ld_accept_s;
            ready_q    <= (state_d == ST_RUN);
            if (rd_accept_s) begin
                read_data_q <= rd_in_range_s ? mem_q[rd_idx_s] : FILL_WORD;
            end
        end
    end

    assign read_data = read_data_q;
    assign rd_valid  = rd_valid_q;
    assign ld_ack    = ld_ack_q;
    assign ready     = ready_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Bench for instr_mem_loadable: a full-size instance and a small DEPTH=8 instance
// checked against an array model of the memory contents.
module tb_instr_mem_loadable;

    localparam logic [9:0] FILL = 10'b0010000010;
    localparam int         DEP  = 1024;
    localparam int         SDEP = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       rd_en, ld_en, ready, rd_valid, ld_ack;
    logic [9:0] address, ld_addr, ld_data, read_data;
    logic       s_rd_en, s_ld_en, s_ready, s_rd_valid, s_ld_ack;
    logic [3:0] s_address, s_ld_addr;
    logic [9:0] s_ld_data, s_read_data;

    int checks   = 0;
    int failures = 0;

    logic [9:0] model_mem [0:DEP-1];
    logic [9:0] model_sm  [0:SDEP-1];
    logic [9:0] exp_last;
    logic [9:0] s_exp_last;

    always #5 clk = ~clk;

    instr_mem_loadable dut (
        .clk(clk), .reset(reset), .rd_en(rd_en), .address(address),
        .read_data(read_data), .rd_valid(rd_valid), .ready(ready),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack)
    );

    instr_mem_loadable #(.DATA_WIDTH(10), .ADDR_WIDTH(4), .DEPTH(SDEP), .FILL_WORD(FILL)) dut_s (
        .clk(clk), .reset(reset), .rd_en(s_rd_en), .address(s_address),
        .read_data(s_read_data), .rd_valid(s_rd_valid), .ready(s_ready),
        .ld_en(s_ld_en), .ld_addr(s_ld_addr), .ld_data(s_ld_data), .ld_ack(s_ld_ack)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en = 1'b0; ld_en = 1'b0; address = 10'd0; ld_addr = 10'd0; ld_data = 10'd0;
        s_rd_en = 1'b0; s_ld_en = 1'b0; s_address = 4'd0; s_ld_addr = 4'd0; s_ld_data = 10'd0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEP; i++) model_mem[i] = FILL;
        for (int i = 0; i < SDEP; i++) model_sm[i] = FILL;
        exp_last   = 10'd0;
        s_exp_last = 10'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rd_en = 1'b1; address = 10'd3; ld_en = 1'b1; ld_addr = 10'd3; ld_data = 10'h3FF;
        s_rd_en = 1'b1; s_ld_en = 1'b1;
        tick();
        model_clear();
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", ready); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        checks++; if (ld_ack !== 1'b0) begin failures++; $display("FAIL reset_ld_ack: got %b expected 0", ld_ack); end
        checks++; if (read_data !== 10'd0) begin failures++; $display("FAIL reset_read_data: got %h expected 000", read_data); end
        checks++; if ({s_ready, s_rd_valid, s_ld_ack} !== 3'b000) begin failures++; $display("FAIL reset_small_flags: got %b expected 000", {s_ready, s_rd_valid, s_ld_ack}); end
        checks++; if (s_read_data !== 10'd0) begin failures++; $display("FAIL reset_small_read_data: got %h expected 000", s_read_data); end
    endtask

    // Reset released; requests hammer both instances while they are still clearing.
    task automatic test_clear_sweep();
        reset = 1'b0;
        for (int k = 1; k <= DEP; k++) begin
            rd_en = 1'b1; address = 10'($urandom); ld_en = 1'b1; ld_addr = 10'($urandom); ld_data = 10'($urandom);
            s_rd_en = (k <= SDEP); s_ld_en = (k <= SDEP);
            s_address = 4'($urandom); s_ld_addr = 4'($urandom_range(0, 7)); s_ld_data = 10'($urandom);
            tick();
            checks++; if (ready !== (k == DEP)) begin failures++; $display("FAIL sweep_ready cycle %0d: got %b expected %b", k, ready, (k == DEP)); end
            checks++; if ({rd_valid, ld_ack} !== 2'b00) begin failures++; $display("FAIL sweep_ignored cycle %0d: got rd_valid,ld_ack=%b expected 00", k, {rd_valid, ld_ack}); end
            if (k <= SDEP + 1) begin
                checks++; if (s_ready !== (k >= SDEP)) begin failures++; $display("FAIL small_sweep_ready cycle %0d: got %b expected %b", k, s_ready, (k >= SDEP)); end
            end
            if (k <= SDEP) begin
                checks++; if ({s_rd_valid, s_ld_ack} !== 2'b00) begin failures++; $display("FAIL small_sweep_ignored cycle %0d: got %b expected 00", k, {s_rd_valid, s_ld_ack}); end
            end
        end
        idle();
    endtask

    // Back-to-back read of every word; the small instance also reads out-of-range addresses.
    task automatic test_fill_reads();
        for (int i = 0; i < DEP; i++) begin
            rd_en = 1'b1; address = 10'(i); exp_last = model_mem[i];
            if (i < 16) begin
                s_rd_en = 1'b1; s_address = 4'(i);
                s_exp_last = (i < SDEP) ? model_sm[i] : FILL;
            end else begin
                s_rd_en = 1'b0;
            end
            tick();
            checks++; if (read_data !== exp_last || rd_valid !== 1'b1) begin failures++; $display("FAIL fill_read addr %0d: got %h/%b expected %h/1", i, read_data, rd_valid, exp_last); end
            checks++; if (s_read_data !== s_exp_last || s_rd_valid !== (i < 16)) begin failures++; $display("FAIL small_read addr %0d: got %h/%b expected %h/%b", i, s_read_data, s_rd_valid, s_exp_last, (i < 16)); end
        end
        idle();
        tick();
        checks++; if (rd_valid !== 1'b0 || read_data !== exp_last) begin failures++; $display("FAIL read_hold: got %h/%b expected %h/0", read_data, rd_valid, exp_last); end
    endtask

    task automatic test_program_load();
        logic [9:0] la [0:2];
        logic [9:0] ldv [0:2];
        la[0] = 10'd1;  ldv[0] = 10'b1100110100;
        la[1] = 10'd2;  ldv[1] = 10'b1100111101;
        la[2] = 10'd10; ldv[2] = 10'b0010000010;
        for (int i = 0; i < 3; i++) begin
            ld_en = 1'b1; ld_addr = la[i]; ld_data = ldv[i];
            tick();
            model_mem[la[i]] = ldv[i];
            checks++; if (ld_ack !== 1'b1) begin failures++; $display("FAIL load_ack %0d: got %b expected 1", i, ld_ack); end
        end
        ld_en = 1'b0;
        for (int a = 1; a <= 3; a++) begin
            rd_en = 1'b1; address = 10'(a); exp_last = model_mem[a];
            tick();
            checks++; if (read_data !== exp_last || rd_valid !== 1'b1) begin failures++; $display("FAIL program_read addr %0d: got %h/%b expected %h/1", a, read_data, rd_valid, exp_last); end
            checks++; if (ld_ack !== 1'b0) begin failures++; $display("FAIL program_ack_clear: got %b expected 0", ld_ack); end
        end
        idle();
    endtask

    task automatic test_collision();
        ld_en = 1'b1; ld_addr = 10'd5; ld_data = 10'h0AA;
        tick();
        model_mem[5] = 10'h0AA;
        rd_en = 1'b1; address = 10'd5; ld_en = 1'b1; ld_addr = 10'd5; ld_data = 10'h155;
        exp_last = model_mem[5];
        tick();
        model_mem[5] = 10'h155;
        checks++; if (read_data !== exp_last || ld_ack !== 1'b1) begin failures++; $display("FAIL collision_read_first: got %h ack %b expected %h ack 1", read_data, ld_ack, exp_last); end
        ld_en = 1'b0; exp_last = model_mem[5];
        tick();
        checks++; if (read_data !== exp_last || rd_valid !== 1'b1) begin failures++; $display("FAIL collision_next: got %h/%b expected %h/1", read_data, rd_valid, exp_last); end
        idle();
    endtask

    task automatic test_out_of_range();
        s_ld_en = 1'b1; s_ld_addr = 4'd12; s_ld_data = 10'h3FF;
        tick();
        checks++; if (s_ld_ack !== 1'b0) begin failures++; $display("FAIL oor_load_ack: got %b expected 0", s_ld_ack); end
        s_ld_en = 1'b0; s_rd_en = 1'b1; s_address = 4'd12; s_exp_last = FILL;
        tick();
        checks++; if (s_read_data !== s_exp_last || s_rd_valid !== 1'b1) begin failures++; $display("FAIL oor_read: got %h/%b expected %h/1", s_read_data, s_rd_valid, s_exp_last); end
        s_address = 4'd4; s_exp_last = model_sm[4];
        tick();
        checks++; if (s_read_data !== s_exp_last) begin failures++; $display("FAIL oor_no_alias: got %h expected %h", s_read_data, s_exp_last); end
        idle();
    endtask

    task automatic test_random(input int n);
        logic e_ack, e_valid, s_e_ack, s_e_valid;
        for (int c = 0; c < n; c++) begin
            rd_en = 1'($urandom); ld_en = 1'($urandom);
            address = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 31)) : 10'($urandom);
            ld_addr = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 31)) : 10'($urandom);
            ld_data = 10'($urandom);
            s_rd_en = 1'($urandom); s_ld_en = 1'($urandom);
            s_address = 4'($urandom); s_ld_addr = 4'($urandom); s_ld_data = 10'($urandom);
            e_valid = rd_en; e_ack = ld_en;
            if (rd_en) exp_last = model_mem[address];
            if (ld_en) model_mem[ld_addr] = ld_data;
            s_e_valid = s_rd_en; s_e_ack = s_ld_en && (s_ld_addr < 4'(SDEP));
            if (s_rd_en) s_exp_last = (s_address < 4'(SDEP)) ? model_sm[s_address[2:0]] : FILL;
            if (s_e_ack) model_sm[s_ld_addr[2:0]] = s_ld_data;
            tick();
            checks++; if ({read_data, rd_valid, ld_ack} !== {exp_last, e_valid, e_ack}) begin failures++; $display("FAIL random cycle %0d: got %h/%b/%b expected %h/%b/%b", c, read_data, rd_valid, ld_ack, exp_last, e_valid, e_ack); end
            checks++; if ({s_read_data, s_rd_valid, s_ld_ack} !== {s_exp_last, s_e_valid, s_e_ack}) begin failures++; $display("FAIL small_random cycle %0d: got %h/%b/%b expected %h/%b/%b", c, s_read_data, s_rd_valid, s_ld_ack, s_exp_last, s_e_valid, s_e_ack); end
        end
        idle();
    endtask

    task automatic test_reset_mid_run();
        int k;
        ld_en = 1'b1; ld_addr = 10'd7; ld_data = 10'h3FF;
        tick();
        ld_en = 1'b0; rd_en = 1'b1; address = 10'd7;
        tick();
        checks++; if (read_data !== 10'h3FF) begin failures++; $display("FAIL pre_reset_read: got %h expected 3ff", read_data); end
        reset = 1'b1; ld_en = 1'b1; ld_addr = 10'd7; ld_data = 10'h123;
        tick();
        model_clear();
        checks++; if ({ready, rd_valid, ld_ack} !== 3'b000 || read_data !== 10'd0) begin failures++; $display("FAIL run_reset: got ready,rd_valid,ld_ack=%b data %h expected 000 data 000", {ready, rd_valid, ld_ack}, read_data); end
        reset = 1'b0; idle();
        for (int i = 0; i < 500; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        k = 0;
        while (ready !== 1'b1 && k < 1100) begin
            tick();
            k++;
        end
        checks++; if (k != DEP) begin failures++; $display("FAIL mid_sweep_restart: got ready after %0d cycles expected %0d", k, DEP); end
    endtask

    initial begin
        idle();
        reset = 1'b1;
        test_reset();
        test_clear_sweep();
        test_fill_reads();
        test_program_load();
        test_collision();
        test_out_of_range();
        test_random(600);
        test_reset_mid_run();
        test_fill_reads();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
